// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), axis region encoding and total-count helper.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_t;

    function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus the region sequencer that walks
// ACTIVE -> FP -> SYNC -> BP, switching exactly at the boundary counts.
//   state      | meaning
//   REG_ACTIVE | count < ACT, visible region
//   REG_FP     | ACT <= count < ACT+FP, front porch
//   REG_SYNC   | ACT+FP <= count < ACT+FP+SYNC, sync pulse
//   REG_BP     | remaining counts up to TOTAL-1, back porch
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT  = VGA_H_ACTIVE,
    parameter int FP   = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP   = VGA_H_BP,
    localparam int TOTAL = vga_total(ACT, FP, SYNC, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output region_t      region,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;
    region_t      region_q, region_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            region_q <= REG_ACTIVE;
        end else begin
            count_q  <= count_d;
            region_q <= region_d;
        end
    end

    always_comb begin
        count_d  = count_q;
        region_d = region_q;
        wrap     = 1'b0;
        if (clr) begin
            count_d  = '0;
            region_d = REG_ACTIVE;
        end else if (inc) begin
            wrap    = (count_q == W'(TOTAL - 1));
            count_d = wrap ? '0 : count_q + 1'b1;
            case (region_q)
                REG_ACTIVE: if (count_d == W'(ACT))               region_d = REG_FP;
                REG_FP:     if (count_d == W'(ACT + FP))          region_d = REG_SYNC;
                REG_SYNC:   if (count_d == W'(ACT + FP + SYNC))   region_d = REG_BP;
                REG_BP:     if (wrap)                             region_d = REG_ACTIVE;
                default:                                          region_d = REG_ACTIVE;
            endcase
        end
    end

    // region reports the region of the count being loaded, so the parent can
    // register its decoded outputs on the same edge that count changes.
    assign count  = count_q;
    assign region = region_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel-rate divider, h/v axis counters and registered,
// mutually aligned sync / video window / line and frame start outputs.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_POL = 0,
    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic          POL      = (SYNC_POL != 0);

    logic [DW-1:0] div_q, div_d;
    logic          pix_tick_q, pix_tick_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic    clr;
    logic    h_wrap, v_wrap;
    region_t h_region, v_region;

    assign clr = ~en;

    vga_axis_counter #(.ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (pix_tick_q),
        .count  (x),
        .region (h_region),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (h_wrap),
        .count  (y),
        .region (v_region),
        .wrap   (v_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~POL;
            vsync_q       <= ~POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // With en low everything collapses to the idle frame origin on the next edge.
    always_comb begin
        div_d         = '0;
        pix_tick_d    = 1'b0;
        hsync_d       = ~POL;
        vsync_d       = ~POL;
        video_on_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en) begin
            div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            pix_tick_d    = (div_q == DIV_LAST);
            hsync_d       = (h_region == REG_SYNC) ~^ POL;
            vsync_d       = (v_region == REG_SYNC) ~^ POL;
            video_on_d    = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
